// File: rtl/prio_encoder_q.sv
// prio_encoder_q: registered priority encoder with sticky request queue, valid/ready output
//   clk         in   clock, rising edge
//   rst_n       in   synchronous reset, active low
//   req_i       in   [N]  request lines, OR-ed into the pending vector every cycle
//   flush_i     in   clears pending vector and drops any output in flight
//   out_valid_o out  out_idx_o holds an index awaiting acceptance
//   out_ready_i in   consumer accepts out_idx_o while out_valid_o is high
//   out_idx_o   out  [IW] delivered request index
//   pend_o      out  [N]  registered pending vector
//   coal_cnt_o  out  [CW] saturating count of requests merged into already-pending bits
module prio_encoder_q #(
  parameter int N = 4,
  parameter int MODE = 0,
  parameter int CW = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          flush_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [IW-1:0] out_idx_o,
  output logic [N-1:0]  pend_o,
  output logic [CW-1:0] coal_cnt_o
);
  localparam int PW = $clog2(N + 1);
  localparam int SW = (CW > PW ? CW : PW) + 1;
  typedef enum logic {S_IDLE, S_SHOW} state_t;
  state_t r_state, w_state_nxt;
  logic [N-1:0]  r_pend, w_above, w_cand, w_clr, w_merge;
  logic [IW-1:0] r_idx, r_ptr, w_hi, w_lo, w_sel;
  logic [CW-1:0] r_coal, w_coal_nxt;
  logic [PW-1:0] w_cnt;
  logic [SW-1:0] w_sum;
  logic          w_load;
  // w_hi: highest pending bit; w_lo: lowest pending bit above rr pointer, else lowest overall (wrap)
  always_comb begin
    w_hi = '0;
    w_lo = '0;
    w_above = '0;
    for (int i = 0; i < N; i++) begin
      w_above[i] = r_pend[i] && (IW'(i) > r_ptr);
      if (r_pend[i]) w_hi = IW'(i);
    end
    w_cand = |w_above ? w_above : r_pend;
    for (int i = N - 1; i >= 0; i--) if (w_cand[i]) w_lo = IW'(i);
  end
  assign w_sel = (MODE != 0) ? w_lo : w_hi;
  assign w_load = |r_pend && (r_state == S_IDLE || out_ready_i);
  assign w_clr = w_load ? (N'(1) << w_sel) : '0;
  // a bit being cleared this cycle counts as a fresh set, not a merge
  assign w_merge = req_i & r_pend & ~w_clr;
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N; i++) w_cnt = w_cnt + PW'(w_merge[i]);
  end
  assign w_sum = SW'(r_coal) + SW'(w_cnt);
  assign w_coal_nxt = (w_sum > SW'({CW{1'b1}})) ? '1 : w_sum[CW-1:0];
  assign w_state_nxt = w_load ? S_SHOW : (r_state == S_SHOW && out_ready_i) ? S_IDLE : r_state;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pend <= '0;
      r_idx <= '0;
      r_coal <= '0;
      r_ptr <= IW'(N - 1);
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_pend <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend <= (r_pend & ~w_clr) | req_i;
      r_coal <= w_coal_nxt;
      if (w_load) begin
        r_idx <= w_sel;
        if (MODE != 0) r_ptr <= w_sel;
      end
    end
  end
  assign out_valid_o = (r_state == S_SHOW);
  assign out_idx_o = r_idx;
  assign pend_o = r_pend;
  assign coal_cnt_o = r_coal;
endmodule

// File: tb/tb_prio_encoder_q.sv
// tb_prio_encoder_q: directed table, hand sequences and random stimulus vs reference model
module tb_prio_encoder_q;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic ready = 1'b0;
  logic [3:0] req = 4'b0;
  logic       dv[3];
  logic [1:0] di[3];
  logic [3:0] dp[3];
  logic [7:0] dc[3];
  logic [1:0] c2;
  always #5 clk = ~clk;
  prio_encoder_q #(.N(4), .MODE(0), .CW(8)) u0 (.clk(clk), .rst_n(rst_n), .req_i(req), .flush_i(flush),
    .out_valid_o(dv[0]), .out_ready_i(ready), .out_idx_o(di[0]), .pend_o(dp[0]), .coal_cnt_o(dc[0]));
  prio_encoder_q #(.N(4), .MODE(1), .CW(8)) u1 (.clk(clk), .rst_n(rst_n), .req_i(req), .flush_i(flush),
    .out_valid_o(dv[1]), .out_ready_i(ready), .out_idx_o(di[1]), .pend_o(dp[1]), .coal_cnt_o(dc[1]));
  prio_encoder_q #(.N(4), .MODE(0), .CW(2)) u2 (.clk(clk), .rst_n(rst_n), .req_i(req), .flush_i(flush),
    .out_valid_o(dv[2]), .out_ready_i(ready), .out_idx_o(di[2]), .pend_o(dp[2]), .coal_cnt_o(c2));
  assign dc[2] = {6'b0, c2};
  int n_cmp = 0;
  int n_bad = 0;
  int mp[3], mv[3], mi[3], mptr[3], mc[3];
  int mode[3] = '{0, 1, 0};
  int cmax[3] = '{255, 255, 3};
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int pick(input int d);
    if (mode[d] == 0) begin
      for (int b = 3; b >= 0; b--) if (mp[d][b]) return b;
    end else begin
      for (int k = 1; k <= 4; k++) if (mp[d][(mptr[d] + k) % 4]) return (mptr[d] + k) % 4;
    end
    return 0;
  endfunction
  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        mp[d] = 0; mv[d] = 0; mi[d] = 0; mc[d] = 0; mptr[d] = 3;
      end else if (flush) begin
        mp[d] = 0; mv[d] = 0;
      end else begin
        int clr = 0;
        if (mp[d] != 0 && (mv[d] == 0 || ready)) begin
          int s = pick(d);
          clr = 1 << s;
          mi[d] = s;
          mv[d] = 1;
          if (mode[d] != 0) mptr[d] = s;
        end else if (mv[d] != 0 && ready) mv[d] = 0;
        for (int b = 0; b < 4; b++) if (req[b] && mp[d][b] && !clr[b]) mc[d]++;
        if (mc[d] > cmax[d]) mc[d] = cmax[d];
        mp[d] = (mp[d] & ~clr | int'(req)) & 15;
      end
    end
  endtask
  task automatic step(input logic [3:0] r, input logic rd, input logic fl, input logic rn);
    req = r; ready = rd; flush = fl; rst_n = rn;
    @(posedge clk);
    model_edge();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("u%0d.valid", d), int'(dv[d]), mv[d]);
      chk($sformatf("u%0d.idx", d), int'(di[d]), mi[d]);
      chk($sformatf("u%0d.pend", d), int'(dp[d]), mp[d]);
      chk($sformatf("u%0d.coal", d), int'(dc[d]), mc[d]);
    end
  endtask
  typedef struct {
    logic [3:0] req;
    logic rdy, fl, rn, ev;
    logic [1:0] ei;
    logic [3:0] ep;
    int ec;
  } vec_t;
  vec_t tv[26];
  function automatic vec_t mk(input logic [3:0] r, input logic rd, input logic fl, input logic rn,
                              input logic ev, input logic [1:0] ei, input logic [3:0] ep, input int ec);
    vec_t v;
    v.req = r; v.rdy = rd; v.fl = fl; v.rn = rn; v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec;
    return v;
  endfunction
  initial begin
    tv[0]  = mk(4'b0011, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0011, 0);
    tv[1]  = mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0001, 0);
    tv[2]  = mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0000, 0);
    tv[3]  = mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 0);
    tv[4]  = mk(4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1100, 0);
    tv[5]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0100, 0);
    tv[6]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0100, 0);
    tv[7]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0100, 0);
    tv[8]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0100, 0);
    tv[9]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0100, 0);
    tv[10] = mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000, 0);
    tv[11] = mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000, 0);
    tv[12] = mk(4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0010, 0);
    tv[13] = mk(4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 0);
    tv[14] = mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0000, 0);
    tv[15] = mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 0);
    tv[16] = mk(4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'b1110, 0);
    tv[17] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0110, 0);
    tv[18] = mk(4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 0);
    tv[19] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 0);
    tv[20] = mk(4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'b1000, 0);
    tv[21] = mk(4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0100, 0);
    tv[22] = mk(4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0100, 1);
    tv[23] = mk(4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0100, 2);
    tv[24] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0100, 2);
    tv[25] = mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 0);
    for (int k = 0; k < 3; k++) step(4'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 26; k++) begin
      step(tv[k].req, tv[k].rdy, tv[k].fl, tv[k].rn);
      chk($sformatf("tbl%0d.valid", k), int'(dv[0]), int'(tv[k].ev));
      chk($sformatf("tbl%0d.idx", k), int'(di[0]), int'(tv[k].ei));
      chk($sformatf("tbl%0d.pend", k), int'(dp[0]), int'(tv[k].ep));
      chk($sformatf("tbl%0d.coal", k), int'(dc[0]), tv[k].ec);
    end
    for (int r = 0; r < 2; r++) begin
      step(4'b1111, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
        step(4'b0, 1'b1, 1'b0, 1'b1);
        chk($sformatf("rr%0d.valid", r), int'(dv[1]), 1);
        chk($sformatf("rr%0d.idx%0d", r, k), int'(di[1]), k);
      end
      step(4'b0, 1'b1, 1'b0, 1'b1);
      chk($sformatf("rr%0d.idle", r), int'(dv[1]), 0);
    end
    for (int k = 0; k < 12; k++) step(4'b0100, 1'b0, 1'b0, 1'b1);
    chk("sat.cw2", int'(dc[2]), 3);
    chk("sat.cw8", int'(dc[0]), 10);
    for (int k = 0; k < 3000; k++)
      step(4'($urandom & $urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 199) != 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
